iter_alu: RTL and testbench

- Next-generation execution ALU for the core, parametrised in data width.
- Keeps the 6-bit aluControl operation select and the in1/in2/out naming.
- Adds logic, shift and set-less-than ops, overflow/zero flags, and iterative multiply/divide into HI/LO registers.
- Sits in EX. The control unit drives a start/ready/done handshake and stalls the pipeline while ready is low.

---
 rtl/iter_alu_pkg.sv | 33 +++
 rtl/iter_muldiv.sv | 125 ++++++++++++
 rtl/iter_alu.sv | 98 +++++++++
 tb/tb_iter_alu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/iter_alu_pkg.sv
// Shared opcode values, FSM state type and opcode classification helpers for iter_alu.
package iter_alu_pkg;

    localparam logic [5:0] OP_SLL       = 6'h00;
    localparam logic [5:0] OP_SRL       = 6'h02;
    localparam logic [5:0] OP_SRA       = 6'h03;
    localparam logic [5:0] OP_MULT      = 6'h18;
    localparam logic [5:0] OP_MULTU     = 6'h19;
    localparam logic [5:0] OP_DIV       = 6'h1A;
    localparam logic [5:0] OP_DIVU      = 6'h1B;
    localparam logic [5:0] OP_ADD       = 6'h20;
    localparam logic [5:0] OP_ADDU      = 6'h21;
    localparam logic [5:0] OP_SUB       = 6'h22;
    localparam logic [5:0] OP_SUBU      = 6'h23;
    localparam logic [5:0] OP_AND       = 6'h24;
    localparam logic [5:0] OP_OR        = 6'h25;
    localparam logic [5:0] OP_XOR       = 6'h26;
    localparam logic [5:0] OP_NOR       = 6'h27;
    localparam logic [5:0] OP_SLT       = 6'h2A;
    localparam logic [5:0] OP_SLTU      = 6'h2B;
    localparam logic [5:0] OP_LOADSTORE = 6'h3F;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;

    function automatic logic is_muldiv(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider producing HI/LO.
// Magnitudes are processed unsigned; signs are restored on the final step.
module iter_muldiv
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div, sgn, neg_lo, neg_hi, div_zero;
    logic [WIDTH-1:0]   a_raw, b_raw, m, acc_hi, acc_lo;
    logic [WIDTH-1:0]   mag_a, mag_b, step_hi, step_lo, fix_hi, fix_lo;
    logic [WIDTH:0]     add_sum, shifted, trial;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        mag_a    = (sgn && a_raw[WIDTH-1]) ? -a_raw : a_raw;
        mag_b    = (sgn && b_raw[WIDTH-1]) ? -b_raw : b_raw;
        add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
        shifted  = {acc_hi, acc_lo[WIDTH-1]};
        trial    = shifted - {1'b0, m};
        if (is_div) begin
            if (trial[WIDTH]) begin
                step_hi = shifted[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_lo ? -prod : prod;
        if (!is_div) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else begin
            fix_hi = neg_hi ? -step_hi : step_hi;
            fix_lo = neg_lo ? -step_lo : step_lo;
        end
    end

    // The last ITER step already carries the sign fix into hi/lo, so the FIX
    // cycle is the one where done is visible and ready is still low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            sgn      <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            b_raw    <= '0;
            m        <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        sgn    <= is_signed(op);
                        a_raw  <= a;
                        b_raw  <= b;
                        ready  <= 1'b0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    acc_hi   <= '0;
                    acc_lo   <= is_div ? mag_a : mag_b;
                    m        <= is_div ? mag_b : mag_a;
                    neg_lo   <= sgn && (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
                    neg_hi   <= sgn && a_raw[WIDTH-1];
                    div_zero <= is_div && (b_raw == '0);
                    count    <= CW'(WIDTH - 1);
                    state    <= ITER;
                end
                ITER: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count - 1'b1;
                    if (count == '0) begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        done  <= 1'b1;
                        state <= FIX;
                    end
                end
                FIX: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Execution ALU: single-cycle arithmetic/logic/shift ops plus iterative mul/div
// behind a start/ready/done handshake.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       aluControl,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum, diff, res;
    logic               res_ovf, res_ill, md_start, md_done, sc_done;

    assign md_start = start && ready && is_muldiv(aluControl);
    assign done     = sc_done | md_done;

    always_comb begin
        shamt   = in2[SHAMT_W-1:0];
        sum     = in1 + in2;
        diff    = in1 - in2;
        res     = '0;
        res_ovf = 1'b0;
        res_ill = 1'b0;
        case (aluControl)
            OP_SLL:                 res = in1 << shamt;
            OP_SRL:                 res = in1 >> shamt;
            OP_SRA:                 res = WIDTH'($signed(in1) >>> shamt);
            OP_ADD: begin
                res     = sum;
                res_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_ADDU, OP_LOADSTORE:  res = sum;
            OP_SUB: begin
                res     = diff;
                res_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUBU:                res = diff;
            OP_AND:                 res = in1 & in2;
            OP_OR:                  res = in1 | in2;
            OP_XOR:                 res = in1 ^ in2;
            OP_NOR:                 res = ~(in1 | in2);
            OP_SLT:                 res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLTU:                res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = '0;
            default:                res_ill = 1'b1;
        endcase
    end

    // out/overflow/zero only move on single-cycle ops; illegal is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            illegal  <= 1'b0;
            sc_done  <= 1'b0;
        end else begin
            sc_done <= 1'b0;
            illegal <= 1'b0;
            if (start && ready && !is_muldiv(aluControl)) begin
                out      <= res;
                overflow <= res_ovf;
                zero     <= (res == '0);
                illegal  <= res_ill;
                sc_done  <= 1'b1;
            end
        end
    end

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (aluControl),
        .a     (in1),
        .b     (in2),
        .ready (ready),
        .done  (md_done),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed cases plus random ops against an
// arithmetic reference model built on 64-bit integers.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [5:0]  aluControl;
    logic [31:0] in1, in2;
    logic        ready, done, overflow, zero, illegal;
    logic [31:0] out, hi, lo;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_out, exp_hi, exp_lo;
    logic        exp_ovf, exp_zero, exp_ill;

    iter_alu dut (
        .clk(clk), .rst(rst), .start(start), .aluControl(aluControl),
        .in1(in1), .in2(in2), .ready(ready), .done(done), .out(out),
        .hi(hi), .lo(lo), .overflow(overflow), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic md_op(input logic [5:0] op);
        return op == 6'h18 || op == 6'h19 || op == 6'h1A || op == 6'h1B;
    endfunction

    // Reference: results straight from integer arithmetic on sign-extended operands.
    task automatic predict(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, s;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'd0;
        ovf = 1'b0;
        exp_ill = 1'b0;
        if (md_op(op)) begin
            case (op)
                6'h18: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
                6'h19: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
                6'h1A: begin
                    if (b == 32'd0) begin exp_lo = 32'hFFFFFFFF; exp_hi = a; end
                    else begin
                        p = 64'(sa / sb); exp_lo = p[31:0];
                        p = 64'(sa % sb); exp_hi = p[31:0];
                    end
                end
                default: begin
                    if (b == 32'd0) begin exp_lo = 32'hFFFFFFFF; exp_hi = a; end
                    else begin exp_lo = a / b; exp_hi = a % b; end
                end
            endcase
        end else begin
            case (op)
                6'h00: r = a << b[4:0];
                6'h02: r = a >> b[4:0];
                6'h03: begin p = 64'(sa >>> b[4:0]); r = p[31:0]; end
                6'h20: begin s = sa + sb; p = 64'(s); r = p[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                6'h21, 6'h3F: r = a + b;
                6'h22: begin s = sa - sb; p = 64'(s); r = p[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: r = (a < b) ? 32'd1 : 32'd0;
                default: exp_ill = 1'b1;
            endcase
            exp_out  = r;
            exp_ovf  = ovf;
            exp_zero = (r == 32'd0);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".out"}, 64'(out), 64'(exp_out));
        chk({tag, ".ovf"}, 64'(overflow), 64'(exp_ovf));
        chk({tag, ".zero"}, 64'(zero), 64'(exp_zero));
        chk({tag, ".ill"}, 64'(illegal), 64'(exp_ill));
        chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    endtask

    // Issues one op when ready, scrambles the inputs afterwards, waits (bounded) for done.
    task automatic applyStimulus(input string tag, input logic [5:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        int lat, low;
        for (int k = 0; k < 60 && !ready; k++) begin @(posedge clk); #1; end
        start = 1'b1; aluControl = op; in1 = a; in2 = b;
        predict(op, a, b);
        @(posedge clk); #1;
        start = 1'b0; aluControl = 6'($urandom); in1 = $urandom; in2 = $urandom;
        if (md_op(op)) begin
            lat = 1; low = 0;
            while (!done && lat < 60) begin
                if (!ready) low++;
                @(posedge clk); #1;
                lat++;
            end
            if (!ready) low++;
            chk({tag, ".latency"}, 64'(lat), 64'd34);
            chk({tag, ".readylow"}, 64'(low), 64'd34);
            checkOutput(tag);
            @(posedge clk); #1;
            chk({tag, ".readyback"}, 64'(ready), 64'd1);
            chk({tag, ".donepulse"}, 64'(done), 64'd0);
        end else begin
            chk({tag, ".ready"}, 64'(ready), 64'd1);
            checkOutput(tag);
        end
    endtask

    initial begin
        logic [5:0]  ops [0:20];
        logic [31:0] specials [0:5];
        int ndone;
        ops = '{6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F, 6'h3E, 6'h01, 6'h1C};
        specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

        rst = 1'b1; start = 1'b0; aluControl = 6'h0; in1 = 32'h0; in2 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready", 64'(ready), 64'd1);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.out", 64'(out), 64'd0);
        chk("reset.hilo", {hi, lo}, 64'd0);
        chk("reset.flags", 64'({overflow, zero, illegal}), 64'd0);
        rst = 1'b0;
        exp_out = 0; exp_hi = 0; exp_lo = 0; exp_ovf = 0; exp_zero = 0; exp_ill = 0;
        @(posedge clk); #1;

        applyStimulus("add_ovf", 6'h20, 32'h7FFFFFFF, 32'h00000001);
        chk("add_ovf.const", {32'(out), 31'd0, overflow}, {32'h80000000, 32'd1});
        applyStimulus("addu", 6'h21, 32'h7FFFFFFF, 32'h00000001);
        chk("addu.const", 64'({overflow, zero}), 64'd0);

        // Back-to-back single-cycle ops: SUB then SLT with start held two cycles.
        start = 1'b1; aluControl = 6'h22; in1 = 32'd5; in2 = 32'd5;
        @(posedge clk); #1;
        chk("b2b.sub.done", 64'(done), 64'd1);
        chk("b2b.sub.out", 64'({out, zero}), {31'd0, 32'd0, 1'b1});
        aluControl = 6'h2A; in1 = 32'hFFFFFFFF; in2 = 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.slt.done", 64'(done), 64'd1);
        chk("b2b.slt.out", 64'(out), 64'd1);
        applyStimulus("sltu", 6'h2B, 32'hFFFFFFFF, 32'h1);
        chk("sltu.const", 64'(out), 64'd0);
        applyStimulus("sra", 6'h03, 32'hF0000000, 32'd4);
        chk("sra.const", 64'(out), 64'hFF000000);
        applyStimulus("srl", 6'h02, 32'hF0000000, 32'd4);
        chk("srl.const", 64'(out), 64'h0F000000);
        applyStimulus("undef", 6'h3E, 32'h12345678, 32'h1);
        chk("undef.const", 64'({out, illegal}), {31'd0, 32'd0, 1'b1});

        applyStimulus("mult", 6'h18, 32'hFFFFFFFE, 32'h3);
        chk("mult.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        applyStimulus("multu", 6'h19, 32'hFFFFFFFE, 32'h3);
        chk("multu.const", {hi, lo}, 64'h00000002_FFFFFFFA);
        applyStimulus("div", 6'h1A, 32'hFFFFFFF9, 32'h2);
        chk("div.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        applyStimulus("divu0", 6'h1B, 32'h7, 32'h0);
        chk("divu0.const", {hi, lo}, 64'h00000007_FFFFFFFF);
        applyStimulus("divmin", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
        chk("divmin.const", {hi, lo}, 64'h00000000_80000000);

        // A start raised while the divider is busy must not be queued.
        applyStimulus("pre_div", 6'h25, 32'h00F0, 32'h0F00);
        start = 1'b1; aluControl = 6'h1A; in1 = 32'd100; in2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; aluControl = 6'h20; in1 = 32'd1; in2 = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 45; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("middiv.ndone", 64'(ndone), 64'd1);
        chk("middiv.hilo", {hi, lo}, {32'd2, 32'd14});
        chk("middiv.out", 64'(out), 64'h0FF0);
        exp_hi = 32'd2; exp_lo = 32'd14;

        // Reset during a MULTU aborts it with no done and clears HI/LO.
        start = 1'b1; aluControl = 6'h19; in1 = 32'h12345; in2 = 32'h6789;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid.ready", 64'(ready), 64'd1);
        chk("rstmid.hilo", {hi, lo}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("rstmid.nodone", 64'(ndone), 64'd0);
        exp_out = 0; exp_hi = 0; exp_lo = 0; exp_ovf = 0; exp_zero = 0; exp_ill = 0;
        applyStimulus("post_rst_add", 6'h20, 32'd10, 32'd20);

        for (int i = 0; i < 40; i++) begin
            logic [5:0]  op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, 20)];
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            applyStimulus($sformatf("rnd%0d_op%h", i, op), op, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
